// File: rtl/ahb_pkg.sv
// Shared AHB encodings, burst-length lookup and burst tracker state constants.
// No timing: types, constants and a pure function only.
// No flow control: nothing in this file holds state.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    // Burst tracker states kept as plain constants for compatibility with older tooling.
    localparam logic [0:0] B_IDLE = 1'b0;
    localparam logic [0:0] B_RUN  = 1'b1;

    // Beats in a burst; INCR is unbounded and reported as 0.
    function automatic logic [4:0] burst_len(input hburst_e b);
        case (b)
            SINGLE:         burst_len = 5'd1;
            INCR:           burst_len = 5'd0;
            WRAP4, INCR4:   burst_len = 5'd4;
            WRAP8, INCR8:   burst_len = 5'd8;
            default:        burst_len = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Follows fixed-length bursts on the muxed bus and flags bursts abandoned before their last beat.
// Latency: early_term is registered, asserted the cycle after the abandoning address phase.
// Backpressure: HREADY low freezes FSM and beat counter; early_term is never raised in a wait state.
module ahb_burst_tracker
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [3:0] HMASTER,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    output logic       early_term,
    output logic [0:0] state,
    output logic [4:0] beats_left,
    output logic [3:0] burst_master
);

    logic [4:0] len;
    logic       start;
    logic       abandon;

    // Classify the current address phase: does it open a fixed burst, does it leave the running one.
    always_comb begin
        len     = burst_len(hburst_e'(HBURST));
        start   = (HTRANS == NONSEQ) && (len > 5'd1);
        abandon = (HMASTER != burst_master) || (HTRANS == IDLE) || (HTRANS == NONSEQ);
    end

    // Burst FSM and remaining-beat counter; BUSY from the owning master simply holds the count.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state        <= B_IDLE;
            beats_left   <= 5'd0;
            burst_master <= 4'd0;
            early_term   <= 1'b0;
        end else begin
            early_term <= 1'b0;
            if (HREADY) begin
                if (state == B_IDLE) begin
                    if (start) begin
                        state        <= B_RUN;
                        beats_left   <= len - 5'd1;
                        burst_master <= HMASTER;
                    end
                end else if (abandon) begin
                    early_term <= (beats_left != 5'd0);
                    if (start) begin
                        beats_left   <= len - 5'd1;
                        burst_master <= HMASTER;
                    end else begin
                        state      <= B_IDLE;
                        beats_left <= 5'd0;
                    end
                end else if (HTRANS == SEQ) begin
                    // Never decrement past zero; the final beat returns to idle.
                    if (beats_left <= 5'd1) begin
                        state      <= B_IDLE;
                        beats_left <= 5'd0;
                    end else begin
                        beats_left <= beats_left - 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ahb_master_mux.sv
// Muxes the granted master's address/control onto the bus and the data-phase master's write data.
// Latency: address/control 0 cycles; write data selected one HREADY-high edge after the address.
// Backpressure: HREADY low holds the data-phase master and data_active (wait states extend the data phase).
module ahb_master_mux
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 16,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [3:0]                    HMASTER,
    input  logic                          HREADY,
    input  logic [NUM_MASTERS*ADDR_W-1:0] HADDRx,
    input  logic [NUM_MASTERS*2-1:0]      HTRANSx,
    input  logic [NUM_MASTERS-1:0]        HWRITEx,
    input  logic [NUM_MASTERS*3-1:0]      HSIZEx,
    input  logic [NUM_MASTERS*3-1:0]      HBURSTx,
    input  logic [NUM_MASTERS*DATA_W-1:0] HWDATAx,
    output logic [ADDR_W-1:0]             HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [DATA_W-1:0]             HWDATA,
    output logic [3:0]                    HMASTER_D,
    output logic                          data_active,
    output logic                          early_term
);

    logic [0:0] trk_state;
    logic [4:0] trk_beats_left;
    logic [3:0] trk_burst_master;

    // Address-phase mux; an HMASTER with no attached master leaves the bus IDLE with zeroed control.
    always_comb begin
        HADDR  = '0;
        HTRANS = IDLE;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        HBURST = 3'd0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (HMASTER == 4'(i)) begin
                HADDR  = HADDRx[i*ADDR_W +: ADDR_W];
                HTRANS = HTRANSx[i*2 +: 2];
                HWRITE = HWRITEx[i];
                HSIZE  = HSIZEx[i*3 +: 3];
                HBURST = HBURSTx[i*3 +: 3];
            end
        end
    end

    // Advance the data-phase master only when the current transfer completes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HMASTER_D   <= 4'd0;
            data_active <= 1'b0;
        end else if (HREADY) begin
            HMASTER_D   <= HMASTER;
            data_active <= (HTRANS == NONSEQ) || (HTRANS == SEQ);
        end
    end

    // Data-phase write-data mux; driven to zero when no real transfer owns the data phase.
    always_comb begin
        HWDATA = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (data_active && (HMASTER_D == 4'(i))) begin
                HWDATA = HWDATAx[i*DATA_W +: DATA_W];
            end
        end
    end

    ahb_burst_tracker u_trk (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HREADY       (HREADY),
        .HMASTER      (HMASTER),
        .HTRANS       (HTRANS),
        .HBURST       (HBURST),
        .early_term   (early_term),
        .state        (trk_state),
        .beats_left   (trk_beats_left),
        .burst_master (trk_burst_master)
    );

endmodule
